// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical scan counters,
// zero-skew registered sync and visibility flags, and a start-of-vblank pulse.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs_n,
  output logic       vs_n,
  output logic       display_on,
  output logic       frame_clk
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_hs_n;
  logic             r_vs_n;
  logic             r_display_on;
  logic             r_frame_clk;

  logic             w_tick;
  logic             w_h_wrap;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_vcnt_nxt;
  logic             w_hs_n_nxt;
  logic             w_vs_n_nxt;
  logic             w_display_on_nxt;
  logic             w_frame_clk_nxt;

  assign w_tick = (r_div_cnt == DIV_LAST);

  // Next-count values; flags are derived from these so they land with the counts.
  always_comb begin
    w_div_nxt  = r_div_cnt;
    w_hcnt_nxt = r_hcnt;
    w_vcnt_nxt = r_vcnt;
    w_h_wrap   = 1'b0;

    w_div_nxt = w_tick ? '0 : (r_div_cnt + DIV_W'(1));

    if (w_tick) begin
      if (r_hcnt == H_LAST) begin
        w_hcnt_nxt = '0;
        w_h_wrap   = 1'b1;
      end else begin
        w_hcnt_nxt = r_hcnt + CNT_W'(1);
      end
    end

    if (w_h_wrap) begin
      w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : (r_vcnt + CNT_W'(1));
    end
  end

  always_comb begin
    w_hs_n_nxt       = 1'b1;
    w_vs_n_nxt       = 1'b1;
    w_display_on_nxt = 1'b0;
    w_frame_clk_nxt  = 1'b0;

    w_hs_n_nxt       = !((w_hcnt_nxt >= H_SYNC_START) && (w_hcnt_nxt <= H_SYNC_END));
    w_vs_n_nxt       = !((w_vcnt_nxt >= V_SYNC_START) && (w_vcnt_nxt <= V_SYNC_END));
    w_display_on_nxt = (w_hcnt_nxt < H_VIS_END) && (w_vcnt_nxt < V_VIS_END);
    // Only the tick that actually moves the counters onto (0, V_VISIBLE) fires.
    w_frame_clk_nxt  = w_tick && (w_hcnt_nxt == '0) && (w_vcnt_nxt == V_VIS_END);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_div_cnt    <= '0;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_hs_n       <= 1'b1;
      r_vs_n       <= 1'b1;
      r_display_on <= 1'b1;
      r_frame_clk  <= 1'b0;
    end else begin
      r_div_cnt    <= w_div_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_hs_n       <= w_hs_n_nxt;
      r_vs_n       <= w_vs_n_nxt;
      r_display_on <= w_display_on_nxt;
      r_frame_clk  <= w_frame_clk_nxt;
    end
  end

  assign pixel_en   = w_tick;
  assign DrawX      = r_hcnt;
  assign DrawY      = r_vcnt;
  assign hs_n       = r_hs_n;
  assign vs_n       = r_vs_n;
  assign display_on = r_display_on;
  assign frame_clk  = r_frame_clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: one default-size instance plus two
// reduced-raster instances (CLK_DIV=2 and CLK_DIV=1) sharing clock and reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fc;
    logic       pe;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_pe, a_hs, a_vs, a_de, a_fc;
  logic [9:0] a_x, a_y;
  logic       b_pe, b_hs, b_vs, b_de, b_fc;
  logic [9:0] b_x, b_y;
  logic       c_pe, c_hs, c_vs, c_de, c_fc;
  logic [9:0] c_x, c_y;

  vga_timing_gen u_a (
    .Clk(clk), .Reset_n(rst_n), .pixel_en(a_pe), .DrawX(a_x), .DrawY(a_y),
    .hs_n(a_hs), .vs_n(a_vs), .display_on(a_de), .frame_clk(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .Clk(clk), .Reset_n(rst_n), .pixel_en(b_pe), .DrawX(b_x), .DrawY(b_y),
    .hs_n(b_hs), .vs_n(b_vs), .display_on(b_de), .frame_clk(b_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_c (
    .Clk(clk), .Reset_n(rst_n), .pixel_en(c_pe), .DrawX(c_x), .DrawY(c_y),
    .hs_n(c_hs), .vs_n(c_vs), .display_on(c_de), .frame_clk(c_fc)
  );

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {a_x, a_y, a_hs, a_vs, a_de, a_fc, a_pe};
  assign obs_b = {b_x, b_y, b_hs, b_vs, b_de, b_fc, b_pe};
  assign obs_c = {c_x, c_y, c_hs, c_vs, c_de, c_fc, c_pe};

  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];
  int unsigned j;
  int checks;
  int errors;

  // Reference: after k edges since reset, k/d pixel ticks have elapsed.
  function automatic obs_t model(input int unsigned k, input bit in_rst, input int unsigned d,
                                 input int unsigned hv, input int unsigned hf,
                                 input int unsigned hs, input int unsigned hb,
                                 input int unsigned vv, input int unsigned vf,
                                 input int unsigned vs, input int unsigned vb);
    obs_t m;
    int unsigned p, ht, vt, x, y;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p  = k / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    m.x  = 10'(x);
    m.y  = 10'(y);
    m.hs = !((x >= hv + hf) && (x < hv + hf + hs));
    m.vs = !((y >= vv + vf) && (y < vv + vf + vs));
    m.de = (x < hv) && (y < vv);
    m.fc = !in_rst && (k != 0) && ((k % d) == 0) && (x == 0) && (y == vv);
    m.pe = ((k % d) == (d - 1));
    return m;
  endfunction

  // Push the expected post-edge state for every instance, then advance one edge.
  task automatic step();
    bit in_rst;
    in_rst = !rst_n;
    if (in_rst) j = 0;
    else j = j + 1;
    q_a.push_back(model(j, in_rst, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    q_b.push_back(model(j, in_rst, 2, 20, 3, 5, 4, 12, 2, 2, 3));
    q_c.push_back(model(j, in_rst, 1, 20, 3, 5, 4, 12, 2, 2, 3));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL reset_a got %h exp %h", obs_a, e); end
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL reset_b got %h exp %h", obs_b, e); end
      e = q_c.pop_front(); checks++;
      if (obs_c !== e) begin errors++; $display("FAIL reset_c got %h exp %h", obs_c, e); end
    end
    checks++;
    if (a_pe !== 1'b0 || a_x !== 10'd0 || a_de !== 1'b1 || a_hs !== 1'b1 || a_fc !== 1'b0) begin
      errors++; $display("FAIL reset_vals got pe=%b x=%0d de=%b hs=%b fc=%b", a_pe, a_x, a_de, a_hs, a_fc);
    end
    checks++;
    if (c_pe !== 1'b1) begin errors++; $display("FAIL reset_pe_div1 got %b exp 1", c_pe); end
    rst_n = 1'b1;
    step();
    e = q_a.pop_front(); checks++;
    if (obs_a !== e) begin errors++; $display("FAIL release1_a got %h exp %h", obs_a, e); end
    checks++;
    if (a_pe !== 1'b1 || a_x !== 10'd0) begin
      errors++; $display("FAIL first_tick got pe=%b x=%0d exp pe=1 x=0", a_pe, a_x);
    end
    step();
    e = q_a.pop_front(); checks++;
    if (obs_a !== e) begin errors++; $display("FAIL release2_a got %h exp %h", obs_a, e); end
    checks++;
    if (a_x !== 10'd1) begin errors++; $display("FAIL first_x got %0d exp 1", a_x); end
    q_b.delete(); q_c.delete();
  endtask

  task automatic test_line();
    obs_t e;
    logic prev_hs, prev_de;
    int cyc, last_fall, fall_cyc, n_period, n_fall;
    prev_hs = a_hs; prev_de = a_de;
    last_fall = -1; fall_cyc = -1; n_period = 0; n_fall = 0;
    for (cyc = 0; cyc < 5200; cyc++) begin
      step();
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL line_sb got %h exp %h", obs_a, e); end
      if (prev_hs && !a_hs) begin
        n_fall++; checks++;
        if (a_x !== 10'd656) begin errors++; $display("FAIL hs_fall_x got %0d exp 656", a_x); end
        if (last_fall >= 0) begin
          n_period++; checks++;
          if ((cyc - last_fall) / 2 != 800) begin
            errors++; $display("FAIL line_ticks got %0d exp 800", (cyc - last_fall) / 2);
          end
        end
        last_fall = cyc; fall_cyc = cyc;
      end
      if (!prev_hs && a_hs && fall_cyc >= 0) begin
        checks++;
        if ((cyc - fall_cyc) / 2 != 96) begin
          errors++; $display("FAIL hs_width got %0d exp 96", (cyc - fall_cyc) / 2);
        end
      end
      if (prev_de && !a_de) begin
        checks++;
        if (a_x !== 10'd640) begin errors++; $display("FAIL de_fall_x got %0d exp 640", a_x); end
      end
      if (!prev_de && a_de) begin
        checks++;
        if (a_x !== 10'd0) begin errors++; $display("FAIL de_rise_x got %0d exp 0", a_x); end
      end
      prev_hs = a_hs; prev_de = a_de;
    end
    checks++;
    if (n_fall < 3 || n_period < 2) begin
      errors++; $display("FAIL hs_events got %0d falls exp 3", n_fall);
    end
    q_b.delete(); q_c.delete();
  endtask

  task automatic test_frame();
    obs_t e;
    logic pb_vs, pc_vs, pb_fc, pc_fc;
    int cyc, b_last, c_last, b_vfall, c_vfall, nb, nc;
    pb_vs = b_vs; pc_vs = c_vs; pb_fc = b_fc; pc_fc = c_fc;
    b_last = -1; c_last = -1; b_vfall = -1; c_vfall = -1; nb = 0; nc = 0;
    for (cyc = 0; cyc < 2700; cyc++) begin
      step();
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL frame_sb_b got %h exp %h", obs_b, e); end
      e = q_c.pop_front(); checks++;
      if (obs_c !== e) begin errors++; $display("FAIL frame_sb_c got %h exp %h", obs_c, e); end
      if (b_fc && !pb_fc) begin
        nb++; checks++;
        if (b_x !== 10'd0 || b_y !== 10'd12 || b_vs !== 1'b1) begin
          errors++; $display("FAIL fc_pos_b got x=%0d y=%0d vs=%b exp 0 12 1", b_x, b_y, b_vs);
        end
        if (b_last >= 0) begin
          checks++;
          if (cyc - b_last != 1216) begin errors++; $display("FAIL fc_period_b got %0d exp 1216", cyc - b_last); end
        end
        b_last = cyc;
      end
      if (c_fc && !pc_fc) begin
        nc++;
        if (c_last >= 0) begin
          checks++;
          if (cyc - c_last != 608) begin errors++; $display("FAIL fc_period_c got %0d exp 608", cyc - c_last); end
        end
        c_last = cyc;
      end
      if (pb_vs && !b_vs) b_vfall = cyc;
      if (!pb_vs && b_vs && b_vfall >= 0) begin
        checks++;
        if (cyc - b_vfall != 128) begin errors++; $display("FAIL vs_width_b got %0d exp 128", cyc - b_vfall); end
      end
      if (pc_vs && !c_vs) c_vfall = cyc;
      if (!pc_vs && c_vs && c_vfall >= 0) begin
        checks++;
        if (cyc - c_vfall != 64) begin errors++; $display("FAIL vs_width_c got %0d exp 64", cyc - c_vfall); end
      end
      pb_vs = b_vs; pc_vs = c_vs; pb_fc = b_fc; pc_fc = c_fc;
    end
    checks++;
    if (nb < 2 || nc < 4) begin errors++; $display("FAIL fc_count got b=%0d c=%0d exp b>=2 c>=4", nb, nc); end
    q_a.delete();
  endtask

  task automatic test_wrap();
    obs_t e;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1300 && !found; i++) begin
      step();
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL wrap_sb got %h exp %h", obs_b, e); end
      if (b_x == 10'd31 && b_y == 10'd18 && b_pe) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL wrap_timeout got x=%0d y=%0d exp 31 18", b_x, b_y);
    end else begin
      step();
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL wrap_sb got %h exp %h", obs_b, e); end
      checks++;
      if (b_x !== 10'd0 || b_y !== 10'd0 || b_de !== 1'b1 || b_hs !== 1'b1 || b_vs !== 1'b1) begin
        errors++; $display("FAIL wrap_vals got x=%0d y=%0d de=%b hs=%b vs=%b exp 0 0 1 1 1",
                           b_x, b_y, b_de, b_hs, b_vs);
      end
    end
    q_a.delete(); q_c.delete();
  endtask

  task automatic test_midframe_reset();
    obs_t e;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1300 && !found; i++) begin
      step();
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL mid_sb got %h exp %h", obs_b, e); end
      if (b_x == 10'd10 && b_y == 10'd6 && b_pe) found = 1'b1;
    end
    q_a.delete(); q_c.delete();
    checks++;
    if (!found) begin
      errors++; $display("FAIL mid_timeout got x=%0d y=%0d exp 10 6", b_x, b_y);
    end else begin
      rst_n = 1'b0;
      step();
      e = q_a.pop_front(); checks++;
      if (obs_a !== e) begin errors++; $display("FAIL mid_rst_a got %h exp %h", obs_a, e); end
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL mid_rst_b got %h exp %h", obs_b, e); end
      e = q_c.pop_front(); checks++;
      if (obs_c !== e) begin errors++; $display("FAIL mid_rst_c got %h exp %h", obs_c, e); end
      checks++;
      if (b_x !== 10'd0 || b_y !== 10'd0 || b_hs !== 1'b1 || b_vs !== 1'b1 ||
          b_de !== 1'b1 || b_fc !== 1'b0 || b_pe !== 1'b0) begin
        errors++; $display("FAIL mid_rst_vals got x=%0d y=%0d hs=%b vs=%b de=%b fc=%b pe=%b",
                           b_x, b_y, b_hs, b_vs, b_de, b_fc, b_pe);
      end
      rst_n = 1'b1;
      step();
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL mid_rel1 got %h exp %h", obs_b, e); end
      checks++;
      if (b_pe !== 1'b1 || b_x !== 10'd0) begin
        errors++; $display("FAIL mid_div_restart got pe=%b x=%0d exp 1 0", b_pe, b_x);
      end
      step();
      e = q_b.pop_front(); checks++;
      if (obs_b !== e) begin errors++; $display("FAIL mid_rel2 got %h exp %h", obs_b, e); end
      checks++;
      if (b_x !== 10'd1) begin errors++; $display("FAIL mid_first_x got %0d exp 1", b_x); end
    end
    q_a.delete(); q_c.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    j = 0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Drives the scan coordinates `DrawX`/`DrawY` consumed by the color mapper and produces the active-low sync strobes for the VGA DAC. Also produces a once-per-frame `frame_clk` pulse that paces object motion logic at the start of vertical blanking.

## Interface
- `CLK_DIV`, 2: `Clk` cycles per pixel; must be ≥1.
- `H_VISIBLE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `Clk` in 1: system clock; the only clock in the block.
- `Reset_n` in 1: synchronous, active-low reset.
- `pixel_en` out 1: pixel tick, high for one `Clk` cycle every `CLK_DIV` cycles.
- `DrawX` out 10: current horizontal count, 0..H_TOTAL-1.
- `DrawY` out 10: current vertical count, 0..V_TOTAL-1.
- `hs_n` out 1: horizontal sync, active low.
- `vs_n` out 1: vertical sync, active low.
- `display_on` out 1: high while (DrawX, DrawY) is inside the visible area.
- `frame_clk` out 1: one-`Clk`-cycle pulse at the start of vertical blanking.

## Operation
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
  - `pixel_en` = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, `pixel_en` is constantly high out of reset.
- Horizontal counter: on each `Clk` edge with `pixel_en` high, `hcnt` increments; H_TOTAL-1 wraps to 0.
- Vertical counter: `vcnt` increments only on the tick where `hcnt` wraps; V_TOTAL-1 wraps to 0, so (H_TOTAL-1, V_TOTAL-1) goes to (0,0).
- Counters hold their value on edges without a tick.
- `DrawX` = hcnt and `DrawY` = vcnt, driven directly from the registers.
- Sync and visibility flags are registered and computed from the next-count values, so they always describe the current `DrawX`/`DrawY` with zero skew:
  - `hs_n` = 0 iff H_VISIBLE+H_FP ≤ DrawX ≤ H_VISIBLE+H_FP+H_SYNC-1 (656..751).
  - `vs_n` = 0 iff V_VISIBLE+V_FP ≤ DrawY ≤ V_VISIBLE+V_FP+V_SYNC-1 (490..491).
  - `display_on` = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
- `frame_clk` is a register set high for exactly one `Clk` cycle, on the edge where the counters move to (0, V_VISIBLE). It is low on every other edge.
- All comparisons are unsigned, 10-bit. Widths cover H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.

## Timing
- Reset:
  - An edge sampled with `Reset_n`=0 forces div_cnt=0, DrawX=0, DrawY=0, hs_n=1, vs_n=1, display_on=1, frame_clk=0, and therefore pixel_en=0 (for CLK_DIV>1).
  - Reset overrides any tick on the same edge, including reset asserted mid-line or mid-frame.
- After reset release: the first `pixel_en` occurs in the CLK_DIV-th cycle. DrawX becomes 1 on the following edge.
- Latency: outputs change only on the tick edge and are stable for CLK_DIV `Clk` cycles.
  - Downstream logic samples (DrawX, DrawY) combinationally.
  - Downstream RGB is valid in the same pixel period.
- Line period: H_TOTAL ticks. Frame period: H_TOTAL×V_TOTAL ticks, i.e. 840,000 `Clk` cycles at the defaults.
- Boundary behaviour:
  - At the simultaneous horizontal and vertical wrap, `display_on` rises on the same edge as the counters reach (0,0).
  - `frame_clk` never coincides with `vs_n` low; it leads the sync by V_FP lines.

## Test plan
- Reset: hold `Reset_n`=0 for 5 cycles -> DrawX=0, DrawY=0, hs_n=1, vs_n=1, display_on=1, frame_clk=0, pixel_en=0. After release, pixel_en=1 in cycle 2 (CLK_DIV=2) and DrawX=1 after that edge.
- Line timing: count ticks between successive `hs_n` falling edges -> 800. `hs_n` falls at DrawX=656 and stays low 96 ticks. `display_on` falls at DrawX=640 and rises at DrawX=0.
- Frame timing: `vs_n` is low exactly for DrawY=490..491 (1,600 ticks). `frame_clk` pulses once per frame, width 1 `Clk` cycle, at (0,480); successive pulses are 840,000 `Clk` cycles apart.
- Wrap: from DrawX=799, DrawY=524, the next tick -> DrawX=0, DrawY=0, display_on=1, hs_n=1, vs_n=1.
- Mid-frame reset: assert `Reset_n`=0 at DrawX=300, DrawY=200, coincident with a tick -> next edge gives all reset values, and the divider restarts from 0.
- Hold and divider override: between ticks, all outputs are unchanged. With CLK_DIV=1, pixel_en is high every cycle and the frame is 420,000 cycles.
